// File: rtl/synth_voice_bank.sv
// synth_voice_bank: CPU-writable parameter bank for NVOICES voices, plus the
// shared sample tick and a sequential, volume-scaled, saturating PCM mixer.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   addr/data_in/wen/ren/data_out/ready
//                       register access: 0..NVOICES-1 voice, NVOICES master,
//                       above that ignored (reads 0, still acknowledged)
//   sample_tick         one-clk strobe every 2**SAMPLECLOCK_DIV clk
//   voice_gate/note/tune/attack/decay
//                       per-voice parameters, updated only on sample_tick
//   voice_pcm           per-voice signed samples, held stable between ticks
//   pcm, pcm_valid      mixed output sample and its one-clk strobe
//
// Optional feature macro: SYNTH_RETRIGGER_EN (re-writing gate=1 to a gated
// voice drops voice_gate for one sample period to restart the envelope).
module synth_voice_bank #(
    parameter int unsigned NVOICES         = 8,
    parameter int unsigned BITDEPTH        = 14,
    parameter int unsigned OUT_W           = 14,
    parameter int unsigned SAMPLECLOCK_DIV = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4:0]                  addr,
    input  logic [31:0]                 data_in,
    output logic [31:0]                 data_out,
    input  logic                        wen,
    input  logic                        ren,
    output logic                        ready,
    output logic                        sample_tick,
    output logic [NVOICES-1:0]          voice_gate,
    output logic [NVOICES*7-1:0]        voice_note,
    output logic [NVOICES*7-1:0]        voice_tune,
    output logic [NVOICES*8-1:0]        voice_attack,
    output logic [NVOICES*8-1:0]        voice_decay,
    input  logic [NVOICES*BITDEPTH-1:0] voice_pcm,
    output logic [OUT_W-1:0]            pcm,
    output logic                        pcm_valid
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned IDX_W  = $clog2(NVOICES);
    localparam int unsigned ACC_W  = BITDEPTH + 4;
    localparam int unsigned PROD_W = ACC_W + 10;
    localparam int unsigned SCL_W  = PROD_W - 8;

    localparam logic signed [SCL_W-1:0] SAT_HI = SCL_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SCL_W-1:0] SAT_LO = ~SAT_HI;

    // Field layout matches the voice register bits [30:0].
    typedef struct packed {
        logic [6:0] tune;
        logic [7:0] attack;
        logic [7:0] decay;
        logic [6:0] note;
        logic       gate;
    } voice_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_SCALE = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Register access / bank state
    logic                       ready_r_q, ready_r_d;
    logic [31:0]                data_out_q, data_out_d;
    voice_t                     stg_q [NVOICES];
    voice_t                     stg_d [NVOICES];
    voice_t                     out_q [NVOICES];
    voice_t                     out_d [NVOICES];
    logic [7:0]                 volume_q, volume_d;
    logic                       mute_q, mute_d;
    logic [NVOICES-1:0]         retrig_q, retrig_d;
    logic [SAMPLECLOCK_DIV-1:0] cnt_q, cnt_d;
    logic                       sample_tick_q, sample_tick_d;

    // Mixer state
    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SCL_W-1:0]    scl_q, scl_d;
    logic [OUT_W-1:0]           pcm_q, pcm_d;
    logic                       pcm_valid_q, pcm_valid_d;

    // Combinational helpers
    logic                       req, commit, wr_en, is_voice, is_master, tick_now;
    logic [IDX_W-1:0]           vidx;
    logic [31:0]                rdata;
    logic signed [BITDEPTH-1:0] vpcm [NVOICES];
    logic [8:0]                 gain;
    logic signed [PROD_W-1:0]   prod;

    // Address decode and readback of the staged contents
    always_comb begin
        req       = wen | ren;
        commit    = req & ~ready_r_q;
        wr_en     = commit & wen;
        is_voice  = addr < ADDR_W'(NVOICES);
        is_master = addr == ADDR_W'(NVOICES);
        vidx      = addr[IDX_W-1:0];
        rdata     = '0;
        if (is_voice) begin
            rdata = {1'b0, stg_q[vidx]};
        end else if (is_master) begin
            rdata = {mute_q, 23'd0, volume_q};
        end
    end

    // Handshake, staging bank writes, tick counter and shadow copy
    always_comb begin
        ready_r_d     = req;
        data_out_d    = data_out_q;
        stg_d         = stg_q;
        out_d         = out_q;
        volume_d      = volume_q;
        mute_d        = mute_q;
        retrig_d      = retrig_q;
        cnt_d         = cnt_q + 1'b1;
        tick_now      = &cnt_q;
        sample_tick_d = tick_now;

        // Read data is captured before the write lands, so wen+ren shows old contents.
        if (commit) begin
            data_out_d = rdata;
        end

        // Shadow copy uses the pre-edge staging bank; a write on this edge waits a period.
        if (tick_now) begin
            for (int i = 0; i < NVOICES; i++) begin
                out_d[i]      = stg_q[i];
                out_d[i].gate = stg_q[i].gate & ~retrig_q[i];
            end
            retrig_d = '0;
        end

        if (wr_en) begin
            if (is_voice) begin
                if (data_in[31]) begin
                    stg_d[vidx] = voice_t'(data_in[30:0]);
                end else begin
                    stg_d[vidx].note = data_in[7:1];
                    stg_d[vidx].gate = data_in[0];
                end
`ifdef SYNTH_RETRIGGER_EN
                if (data_in[0] && stg_q[vidx].gate) begin
                    retrig_d[vidx] = 1'b1;
                end
`endif
            end else if (is_master) begin
                volume_d = data_in[7:0];
                mute_d   = data_in[31];
            end
        end
    end

    // Unpack the flat voice sample bus
    always_comb begin
        for (int i = 0; i < NVOICES; i++) begin
            vpcm[i] = voice_pcm[BITDEPTH*i +: BITDEPTH];
        end
    end

    // Mixer FSM: next state and datapath
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        scl_d       = scl_q;
        pcm_d       = pcm_q;
        pcm_valid_d = 1'b0;
        gain        = {1'b0, volume_q} + 9'd1;
        prod        = PROD_W'(acc_q) * PROD_W'($signed({1'b0, gain}));

        case (state_q)
            S_IDLE: begin
                if (sample_tick_q) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = acc_q + ACC_W'(vpcm[idx_q]);
                if (idx_q == IDX_W'(NVOICES - 1)) begin
                    state_d = S_SCALE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_SCALE: begin
                scl_d   = mute_q ? '0 : SCL_W'(prod >>> 8);
                state_d = S_OUT;
            end
            S_OUT: begin
                if (scl_q > SAT_HI) begin
                    pcm_d = OUT_W'(SAT_HI);
                end else if (scl_q < SAT_LO) begin
                    pcm_d = OUT_W'(SAT_LO);
                end else begin
                    pcm_d = OUT_W'(scl_q);
                end
                pcm_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r_q     <= 1'b0;
            data_out_q    <= '0;
            volume_q      <= 8'hFF;
            mute_q        <= 1'b0;
            retrig_q      <= '0;
            cnt_q         <= '0;
            sample_tick_q <= 1'b0;
            for (int i = 0; i < NVOICES; i++) begin
                stg_q[i] <= '0;
                out_q[i] <= '0;
            end
            state_q       <= S_IDLE;
            idx_q         <= '0;
            acc_q         <= '0;
            scl_q         <= '0;
            pcm_q         <= '0;
            pcm_valid_q   <= 1'b0;
        end else begin
            ready_r_q     <= ready_r_d;
            data_out_q    <= data_out_d;
            volume_q      <= volume_d;
            mute_q        <= mute_d;
            retrig_q      <= retrig_d;
            cnt_q         <= cnt_d;
            sample_tick_q <= sample_tick_d;
            stg_q         <= stg_d;
            out_q         <= out_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            scl_q         <= scl_d;
            pcm_q         <= pcm_d;
            pcm_valid_q   <= pcm_valid_d;
        end
    end

    // Flatten shadowed voice parameters onto the output buses
    always_comb begin
        for (int i = 0; i < NVOICES; i++) begin
            voice_gate[i]          = out_q[i].gate;
            voice_note[7*i +: 7]   = out_q[i].note;
            voice_tune[7*i +: 7]   = out_q[i].tune;
            voice_attack[8*i +: 8] = out_q[i].attack;
            voice_decay[8*i +: 8]  = out_q[i].decay;
        end
    end

    assign ready       = ready_r_q & req;
    assign data_out    = data_out_q;
    assign sample_tick = sample_tick_q;
    assign pcm         = pcm_q;
    assign pcm_valid   = pcm_valid_q;

endmodule

// File: tb/tb_synth_voice_bank.sv
// Directed bench for synth_voice_bank: register access, shadowing, tick
// timing, mixer arithmetic via a scoreboard queue, reset mid-mix, retrigger.
module tb_synth_voice_bank;

    localparam int NV = 8;
    localparam int BD = 14;
    localparam int OW = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        addr;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              wen;
    logic              ren;
    logic              ready;
    logic              sample_tick;
    logic [NV-1:0]     voice_gate;
    logic [NV*7-1:0]   voice_note;
    logic [NV*7-1:0]   voice_tune;
    logic [NV*8-1:0]   voice_attack;
    logic [NV*8-1:0]   voice_decay;
    logic [NV*BD-1:0]  voice_pcm;
    logic [OW-1:0]     pcm;
    logic              pcm_valid;

    synth_voice_bank #(
        .NVOICES(NV), .BITDEPTH(BD), .OUT_W(OW), .SAMPLECLOCK_DIV(8)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(data_out),
        .wen(wen), .ren(ren), .ready(ready), .sample_tick(sample_tick),
        .voice_gate(voice_gate), .voice_note(voice_note), .voice_tune(voice_tune),
        .voice_attack(voice_attack), .voice_decay(voice_decay),
        .voice_pcm(voice_pcm), .pcm(pcm), .pcm_valid(pcm_valid)
    );

    always #5 clk = ~clk;

    // Edges since reset release
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    int total = 0;
    int bad   = 0;
    int exp_q [$];
    int vv [NV];
    int cur_vol = 255;
    bit cur_mute = 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int at);
        int n;
        n  = 0;
        at = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 600);
        total++;
        assert (sample_tick === 1'b1) else begin
            bad++;
            $error("FAIL tick_timeout: observed=none expected=sample_tick");
        end
        if (sample_tick) at = cyc;
    endtask

    task automatic bus_access(input logic [4:0] a, input logic [31:0] d, input bit w, input bit r,
                              output logic [31:0] rd);
        int n;
        @(negedge clk);
        addr    = a;
        data_in = d;
        wen     = w;
        ren     = r;
        n       = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 10);
        total++;
        assert (ready === 1'b1) else begin
            bad++;
            $error("FAIL ready_timeout: observed=%b expected=1", ready);
        end
        rd  = data_out;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        logic [31:0] rd;
        bus_access(a, d, 1'b1, 1'b0, rd);
        if (a == 5'(NV)) begin
            cur_vol  = int'(d[7:0]);
            cur_mute = d[31];
        end
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] rd);
        bus_access(a, 32'd0, 1'b0, 1'b1, rd);
    endtask

    task automatic set_pcm(input int i, input int v);
        vv[i] = v;
        voice_pcm[BD*i +: BD] = BD'(v);
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < NV; i++) set_pcm(i, v);
    endtask

    // Reference mix: sum, scale by (volume+1)/256 with floor, clamp to OUT_W.
    function automatic int mix_model();
        int s;
        int p;
        s = 0;
        for (int i = 0; i < NV; i++) s += vv[i];
        if (cur_mute) return 0;
        p = (s * (cur_vol + 1)) >>> 8;
        if (p > (2 ** (OW - 1)) - 1) p = (2 ** (OW - 1)) - 1;
        if (p < -(2 ** (OW - 1))) p = -(2 ** (OW - 1));
        return p;
    endfunction

    task automatic mix_check(input string tag);
        int t;
        int n;
        int e;
        wait_tick(t);
        exp_q.push_back(mix_model());
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pcm_valid && n < 20);
        total++;
        assert (pcm_valid === 1'b1) else begin
            bad++;
            $error("FAIL %s_valid_timeout: observed=none expected=pcm_valid", tag);
        end
        e = exp_q.pop_front();
        if (pcm_valid) begin
            check(tag, $signed(pcm), e);
            check({tag, "_latency"}, cyc - t, 11);
        end
    endtask

    initial begin
        int t;
        logic [31:0] rd;

        rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; data_in = '0; voice_pcm = '0;
        for (int i = 0; i < NV; i++) vv[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Reset state
        #1;
        check("rst_gate", voice_gate, 0);
        check("rst_note", voice_note, 0);
        check("rst_tune", voice_tune, 0);
        check("rst_attack", voice_attack, 0);
        check("rst_decay", voice_decay, 0);
        check("rst_pcm", pcm, 0);
        check("rst_pcm_valid", pcm_valid, 0);
        check("rst_tick", sample_tick, 0);
        check("rst_ready", ready, 0);

        // Tick timing from reset release
        wait_tick(t);
        check("tick1_cycle", t, 256);
        wait_tick(t);
        check("tick2_cycle", t, 512);
        check("idle_pcm", pcm, 0);
        bus_read(5'd8, rd);
        check("master_rst_read", rd, 32'h0000_00FF);

        // Full-field write, shadowed until the tick
        bus_write(5'd3, 32'h85F0_4079);
        check("v3_before_tick", voice_gate[3], 0);
        wait_tick(t);
        check("v3_note", voice_note[21 +: 7], 7'h3C);
        check("v3_gate", voice_gate[3], 1);
        check("v3_attack", voice_attack[24 +: 8], 8'hF0);
        check("v3_decay", voice_decay[24 +: 8], 8'h40);
        check("v3_tune", voice_tune[21 +: 7], 7'h05);

        // Note/gate-only write keeps the envelope fields
        bus_write(5'd3, 32'h0000_0000);
        wait_tick(t);
        check("v3b_note", voice_note[21 +: 7], 0);
        check("v3b_gate", voice_gate[3], 0);
        check("v3b_attack", voice_attack[24 +: 8], 8'hF0);
        check("v3b_decay", voice_decay[24 +: 8], 8'h40);
        check("v3b_tune", voice_tune[21 +: 7], 7'h05);
        bus_read(5'd3, rd);
        check("v3_readback", rd, 32'h05F0_4000);

        // Held write: one commit on the first cycle, later data ignored
        @(negedge clk);
        addr = 5'd1; data_in = 32'h8000_1103; wen = 1'b1;
        #1 check("hold_ready_c1", ready, 0);
        @(negedge clk);
        check("hold_ready_c2", ready, 1);
        data_in = 32'h8000_2205;
        @(negedge clk);
        check("hold_ready_c3", ready, 1);
        @(negedge clk);
        check("hold_ready_c4", ready, 1);
        wen = 1'b0;
        #1 check("hold_ready_drop", ready, 0);
        bus_read(5'd1, rd);
        check("hold_single_commit", rd, 32'h0000_1103);

        // Out-of-range address
        bus_write(5'd20, 32'hFFFF_FFFF);
        bus_read(5'd20, rd);
        check("oob_read", rd, 0);
        bus_read(5'd3, rd);
        check("oob_v3_intact", rd, 32'h05F0_4000);
        bus_read(5'd8, rd);
        check("oob_master_intact", rd, 32'h0000_00FF);

        // wen+ren together: write, with pre-write data returned
        bus_access(5'd2, 32'h8012_3457, 1'b1, 1'b1, rd);
        check("wr_rd_prewrite", rd, 0);
        bus_read(5'd2, rd);
        check("wr_rd_postwrite", rd, 32'h0012_3457);

        // Mixer
        set_all(4000);
        mix_check("mix_sat_hi");
        for (int i = 0; i < NV; i++) set_pcm(i, (i % 2 == 0) ? 100 : -100);
        mix_check("mix_cancel");
        set_all(-4000);
        mix_check("mix_sat_lo");
        bus_write(5'd8, 32'h0000_007F);
        set_all(512);
        mix_check("mix_vol7f");
        bus_write(5'd8, 32'h0000_0000);
        set_all(1000);
        mix_check("mix_vol0");
        set_all(-1);
        mix_check("mix_vol0_neg");
        bus_write(5'd8, 32'h8000_00FF);
        set_all(4000);
        mix_check("mix_mute");
        bus_read(5'd8, rd);
        check("master_mute_read", rd, 32'h8000_00FF);
        bus_write(5'd8, 32'h0000_00FF);
        set_all(512);
        mix_check("mix_unity");

        // Reset during accumulation
        wait_tick(t);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        cur_vol = 255;
        cur_mute = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (pcm_valid) seen++;
            end
            check("midmix_no_valid", seen, 0);
        end
        check("midmix_pcm", pcm, 0);
        check("midmix_gate_cleared", voice_gate, 0);
        wait_tick(t);
        check("midmix_next_tick", t, 256);

        // Gate re-write on an already-gated voice
        bus_write(5'd5, 32'h0000_0001);
        wait_tick(t);
        check("retrig_gate_on", voice_gate[5], 1);
        bus_write(5'd5, 32'h0000_0001);
        wait_tick(t);
`ifdef SYNTH_RETRIGGER_EN
        check("retrig_gate_low", voice_gate[5], 0);
`else
        check("retrig_gate_stays", voice_gate[5], 1);
`endif
        wait_tick(t);
        check("retrig_gate_back", voice_gate[5], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synth_voice_bank.md
Name: synth_voice_bank

Overview:
Multi-voice successor to the single-gate synth interface. Holds a CPU-writable parameter bank for NVOICES voices and a master control register, and generates the shared sample tick. Presents per-voice parameters to the voice instances, synchronised to that tick. Mixes the voices' PCM outputs sequentially into one saturated, volume-scaled sample for the DAC.

Parameters:
NVOICES, 8, number of voices (2..16)
BITDEPTH, 14, signed width of each voice PCM input
OUT_W, 14, signed width of the mixed PCM output
SAMPLECLOCK_DIV, 8, sample tick every 2**SAMPLECLOCK_DIV clk cycles; must satisfy 2**SAMPLECLOCK_DIV > NVOICES+3

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
addr  in  5  register index: 0..NVOICES-1 = voice, NVOICES = master
data_in  in  32  write data
data_out  out  32  read data; valid while ready=1
wen  in  1  write request, held until ready
ren  in  1  read request, held until ready
ready  out  1  access acknowledge
sample_tick  out  1  one-clk strobe per sample period
voice_gate  out  NVOICES  per-voice gate
voice_note  out  NVOICES*7  per-voice note, voice i at [7i+6:7i]
voice_tune  out  NVOICES*7  per-voice tuning
voice_attack  out  NVOICES*8  per-voice attack rate
voice_decay  out  NVOICES*8  per-voice decay rate
voice_pcm  in  NVOICES*BITDEPTH  signed voice samples, voice i at [BITDEPTH*i +: BITDEPTH]
pcm  out  OUT_W  mixed signed sample
pcm_valid  out  1  one-clk strobe when pcm updates

Behaviour:
- Reset: all voice registers 0; volume 8'hFF; mute 0; all outputs 0; tick counter 0.
- Voice register format: [31] cfg, [30:24] tune, [23:16] attack, [15:8] decay, [7:1] note, [0] gate.
- Voice write with cfg=1 updates all fields.
- Voice write with cfg=0 updates note and gate only; tune, attack and decay keep their values.
- Voice readback returns stored fields, with bit 31 always 0.
- Master register: [7:0] volume, [31] mute. Reads return these bits, with other bits 0.
- addr > NVOICES: writes ignored, reads return 0, ready still given.
- Handshake:
  - ready_r sets on the first cycle wen|ren is seen.
  - ready = ready_r & (wen|ren).
  - The write commits on the cycle ready_r sets; one commit per request.
  - ready_r clears the cycle after wen and ren are both low.
  - wen and ren together: treated as a write, and data_out shows pre-write contents.
- Tick generator:
  - Free-running counter, SAMPLECLOCK_DIV bits.
  - sample_tick = 1 for one clk when the counter wraps to 0. First tick at cycle 2**SAMPLECLOCK_DIV after reset release.
- Shadowing:
  - CPU writes land in a staging bank.
  - The voice_* outputs copy the staging bank on the same edge that raises sample_tick, so voices never see a mid-period change.
  - A write on the cycle of the tick edge is applied at the next tick.
- Mixer FSM: IDLE -> ACC -> SCALE -> OUT -> IDLE.
  - IDLE: on sample_tick, clear accumulator (signed, BITDEPTH+4 bits) and set idx=0.
  - ACC: add sign-extended voice idx each cycle; idx 0..NVOICES-1, then SCALE.
  - SCALE: product = acc*(volume+1), arithmetic shift right 8. volume 0xFF is unity; volume 0 gives acc/256. mute forces 0.
  - OUT: saturate to OUT_W (clamp to +2^(OUT_W-1)-1 / -2^(OUT_W-1)). Register into pcm and pulse pcm_valid.
  - Latency: pcm_valid exactly NVOICES+3 clk after sample_tick.
  - voice_pcm is sampled during ACC; the voices must hold outputs stable between ticks.
- Reset mid-mix: FSM returns to IDLE, pcm=0, and no pcm_valid is issued.

Optional Feature:
SYNTH_RETRIGGER_EN.
- Defined: a write of gate=1 to a voice whose staged gate is already 1 forces voice_gate low for one sample period, then high at the following tick. This restarts the envelope.
- Undefined: such writes leave the gate at 1, with no output change.

Test Plan:
- Reset, idle 300 clk -> first sample_tick at cycle 256, next at 512; all voice_* = 0; pcm = 0.
- Write voice 3 = 0x85F0_4079, then write 0x0000_0000 -> voice 3 shows note 0x3C, gate 1, attack F0, decay 40, tune 0x05 after the next tick. After the second write: tune/attack/decay are unchanged, note and gate are 0. Readback returns 0x05F0_4000.
- Hold wen for 4 cycles -> ready high from cycle 2 while wen is high, single commit; ready low the cycle wen drops. Write to addr 20 -> ready given, bank unchanged; read of addr 20 returns 0.
- All 8 voices at +4000, volume 0xFF -> pcm saturates to +8191 with pcm_valid at tick+11. Voices +100/-100 alternating -> pcm 0. Volume 0x7F with all voices at +512 -> pcm 2048.
- mute=1 -> pcm 0 on the next valid. Assert rst during ACC -> no pcm_valid; pcm 0; next tick 256 clk after rst release.
- With SYNTH_RETRIGGER_EN, rewrite gate=1 -> voice_gate low for exactly one tick period, then high. Without it, gate stays high.
